// File: rtl/intcode_host_pkg.sv
`default_nettype none
// ==========================================================================
// intcode_host_pkg -- shared types and constants for the Intcode host
// Rev 1.0
// ==========================================================================
package intcode_host_pkg;

   localparam int WordSize     = 64;
   localparam int PatchNounIdx = 1;
   localparam int PatchVerbIdx = 2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      CORE_RST = 3'd1,
      LOAD     = 3'd2,
      RUN      = 3'd3,
      DONE     = 3'd4,
      ERROR    = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_OVERFLOW = 2'd1,
      ERR_TIMEOUT  = 2'd2
   } err_e;

   // States from which a new program may be launched; all others count as busy.
   function automatic logic accepts_start(input state_e s);
      return (s == IDLE) || (s == DONE) || (s == ERROR);
   endfunction

endpackage
`default_nettype wire

// File: rtl/intcode_host_if.sv
`default_nettype none
// ==========================================================================
// intcode_host_if -- program word stream (valid/ready with last marker)
// Rev 1.0
// ==========================================================================
interface intcode_host_if;
   import intcode_host_pkg::*;

   logic                in_valid;
   logic                in_ready;
   logic                in_last;
   logic [WordSize-1:0] in_word;

   modport master (output in_valid, output in_last, output in_word, input in_ready);
   modport slave  (input in_valid, input in_last, input in_word, output in_ready);

endinterface
`default_nettype wire

// File: rtl/intcode_host_timer.sv
`default_nettype none
// ==========================================================================
// intcode_host_timer -- loadable 32-bit cycle counter with terminal flag
// Rev 1.0
// ==========================================================================
module intcode_host_timer #(
   parameter logic [31:0] TERM_COUNT = 32'd65534
) (
   input  wire logic        clk,
   input  wire logic        reset,
   input  wire logic        load_i,
   input  wire logic [31:0] load_val_i,
   input  wire logic        en_i,
   output logic             tc_o
);

   logic [31:0] count_q;
   logic [31:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (en_i) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == TERM_COUNT);

endmodule
`default_nettype wire

// File: rtl/intcode_host.sv
`default_nettype none
// ==========================================================================
// intcode_host -- streams a program into an Intcode core, runs it and
// captures the halt result. Rev 1.0
// ==========================================================================
module intcode_host
   import intcode_host_pkg::*;
#(
   parameter int MaxWords      = 256,
   parameter int TimeoutCycles = 65535
) (
   input  wire logic                clk,
   input  wire logic                reset,
   input  wire logic                start_i,
   input  wire logic                patch_en_i,
   input  wire logic [WordSize-1:0] noun_i,
   input  wire logic [WordSize-1:0] verb_i,
   intcode_host_if.slave            in_if,
   output logic                     core_reset_o,
   output logic                     core_write_program_o,
   output logic                     core_run_program_o,
   inout  wire  [WordSize-1:0]      core_data_io,
   input  wire logic                core_halt_i,
   output logic [WordSize-1:0]      result_o,
   output logic                     result_valid_o,
   output logic                     busy_o,
   output logic [1:0]               error_code_o
);

   localparam int          IdxW     = (MaxWords > 1) ? $clog2(MaxWords) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(MaxWords - 1);
   localparam logic [31:0] TimeoutLast = 32'(TimeoutCycles - 1);

   state_e              state_q;
   err_e                error_q;
   logic [IdxW-1:0]     idx_q;
   logic                patch_q;
   logic [WordSize-1:0] noun_q;
   logic [WordSize-1:0] verb_q;
   logic                in_ready_q;
   logic                wr_q;
   logic [WordSize-1:0] wdata_q;
   logic                last_q;
   logic                ovf_q;
   logic                core_rst_q;
   logic                run_q;
   logic [WordSize-1:0] result_q;
   logic                result_valid_q;

   logic                patched_word_sel;
   logic [WordSize-1:0] patched_word;
   logic                timer_tc;

   // Counter sits at zero outside RUN so the first RUN cycle sees count 0.
   intcode_host_timer #(
      .TERM_COUNT (TimeoutLast)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load_i     (state_q != RUN),
      .load_val_i (32'd0),
      .en_i       (state_q == RUN),
      .tc_o       (timer_tc)
   );

   always_comb begin
      patched_word     = in_if.in_word;
      patched_word_sel = 1'b0;
      if (patch_q && (idx_q == IdxW'(PatchNounIdx))) begin
         patched_word     = noun_q;
         patched_word_sel = 1'b1;
      end else if (patch_q && (idx_q == IdxW'(PatchVerbIdx))) begin
         patched_word     = verb_q;
         patched_word_sel = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         error_q        <= ERR_NONE;
         idx_q          <= '0;
         patch_q        <= 1'b0;
         noun_q         <= '0;
         verb_q         <= '0;
         in_ready_q     <= 1'b0;
         wr_q           <= 1'b0;
         wdata_q        <= '0;
         last_q         <= 1'b0;
         ovf_q          <= 1'b0;
         core_rst_q     <= 1'b0;
         run_q          <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         result_valid_q <= 1'b0;
         wr_q           <= 1'b0;
         core_rst_q     <= 1'b0;
         case (state_q)
            IDLE, DONE, ERROR: begin
               if (start_i) begin
                  state_q    <= CORE_RST;
                  core_rst_q <= 1'b1;
                  run_q      <= 1'b0;
                  error_q    <= ERR_NONE;
                  patch_q    <= patch_en_i;
                  noun_q     <= noun_i;
                  verb_q     <= verb_i;
               end
            end
            CORE_RST: begin
               state_q    <= LOAD;
               idx_q      <= '0;
               in_ready_q <= 1'b1;
               last_q     <= 1'b0;
               ovf_q      <= 1'b0;
            end
            LOAD: begin
               // A pending flag means the final write cycle is on the bus now.
               if (last_q) begin
                  state_q <= RUN;
                  run_q   <= 1'b1;
               end else if (ovf_q) begin
                  state_q <= ERROR;
                  error_q <= ERR_OVERFLOW;
               end else if (in_if.in_valid && in_ready_q) begin
                  wr_q    <= 1'b1;
                  wdata_q <= patched_word;
                  idx_q   <= idx_q + IdxW'(1);
                  if (in_if.in_last) begin
                     last_q     <= 1'b1;
                     in_ready_q <= 1'b0;
                  end else if (idx_q == LastIdx) begin
                     ovf_q      <= 1'b1;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (core_halt_i) begin
                  result_q       <= core_data_io;
                  result_valid_q <= 1'b1;
                  state_q        <= DONE;
               end else if (timer_tc) begin
                  state_q <= ERROR;
                  run_q   <= 1'b0;
                  error_q <= ERR_TIMEOUT;
               end
            end
            default: begin
               state_q    <= IDLE;
               run_q      <= 1'b0;
               in_ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_if.in_ready       = in_ready_q;
   assign core_reset_o         = reset | core_rst_q;
   assign core_write_program_o = wr_q;
   assign core_run_program_o   = run_q;
   assign core_data_io         = (wr_q && (state_q == LOAD)) ? wdata_q : {WordSize{1'bz}};
   assign result_o             = result_q;
   assign result_valid_o       = result_valid_q;
   assign busy_o               = !accepts_start(state_q);
   assign error_code_o         = error_q;

endmodule
`default_nettype wire

// File: tb/tb_intcode_host.sv
`default_nettype none
// ==========================================================================
// tb_intcode_host -- host wired to a behavioural Intcode core (instance A)
// and to a silent core stub with small limits (instance B). Rev 1.0
// ==========================================================================
module tb_intcode_host;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;

   intcode_host_if a_if ();
   intcode_host_if b_if ();

   logic        a_start, a_patch, b_start, b_patch;
   logic [63:0] a_noun, a_verb, b_noun, b_verb;
   logic        a_core_rst, a_core_wr, a_core_run, a_core_halt, a_rv, a_busy;
   logic        b_core_rst, b_core_wr, b_core_run, b_rv, b_busy;
   logic        b_core_halt = 1'b0;
   logic [63:0] a_result, b_result;
   logic [1:0]  a_err, b_err;
   wire  [63:0] a_bus;
   wire  [63:0] b_bus;

   intcode_host #(.MaxWords(256), .TimeoutCycles(65535)) u_a (
      .clk(clk), .reset(reset), .start_i(a_start), .patch_en_i(a_patch),
      .noun_i(a_noun), .verb_i(a_verb), .in_if(a_if.slave),
      .core_reset_o(a_core_rst), .core_write_program_o(a_core_wr),
      .core_run_program_o(a_core_run), .core_data_io(a_bus), .core_halt_i(a_core_halt),
      .result_o(a_result), .result_valid_o(a_rv), .busy_o(a_busy), .error_code_o(a_err));

   intcode_host #(.MaxWords(8), .TimeoutCycles(16)) u_b (
      .clk(clk), .reset(reset), .start_i(b_start), .patch_en_i(b_patch),
      .noun_i(b_noun), .verb_i(b_verb), .in_if(b_if.slave),
      .core_reset_o(b_core_rst), .core_write_program_o(b_core_wr),
      .core_run_program_o(b_core_run), .core_data_io(b_bus), .core_halt_i(b_core_halt),
      .result_o(b_result), .result_valid_o(b_rv), .busy_o(b_busy), .error_code_o(b_err));

   // Behavioural Intcode core: add, multiply, halt; one instruction per cycle.
   logic [63:0] a_mem [0:255];
   logic [7:0]  a_wptr, a_pc;
   logic        a_halted;
   always @(posedge clk) begin
      if (a_core_rst) begin
         a_wptr <= 8'd0; a_pc <= 8'd0; a_halted <= 1'b0;
      end else if (a_core_wr) begin
         a_mem[a_wptr] <= a_bus; a_wptr <= a_wptr + 8'd1;
      end else if (a_core_run && !a_halted) begin
         case (a_mem[a_pc])
            64'd1: a_mem[a_mem[a_pc+8'd3][7:0]] <= a_mem[a_mem[a_pc+8'd1][7:0]] + a_mem[a_mem[a_pc+8'd2][7:0]];
            64'd2: a_mem[a_mem[a_pc+8'd3][7:0]] <= a_mem[a_mem[a_pc+8'd1][7:0]] * a_mem[a_mem[a_pc+8'd2][7:0]];
            default: a_halted <= 1'b1;
         endcase
         a_pc <= a_pc + 8'd4;
      end
   end
   assign a_core_halt = a_halted && a_core_run;
   assign a_bus = a_core_halt ? a_mem[0] : 64'bz;

   // Bus and write-timing monitor plus write/result_valid logs.
   logic        a_prev_acc = 1'b0, b_prev_acc = 1'b0;
   int          mon_bad = 0, a_wcnt = 0, b_wcnt = 0, a_rvcnt = 0;
   logic [63:0] wlog [0:63];
   always @(posedge clk) begin
      a_prev_acc <= a_if.in_valid && a_if.in_ready && !reset;
      b_prev_acc <= b_if.in_valid && b_if.in_ready && !reset;
   end
   always @(negedge clk) begin
      if ((a_core_wr !== a_prev_acc) || (b_core_wr !== b_prev_acc) ||
          (a_core_wr && a_core_halt) ||
          ((a_core_wr || a_core_halt) && $isunknown(a_bus)) ||
          (b_core_wr && $isunknown(b_bus)))
         mon_bad <= mon_bad + 1;
      if (a_core_wr === 1'b1) begin
         wlog[a_wcnt % 64] <= a_bus; a_wcnt <= a_wcnt + 1;
      end
      if (b_core_wr === 1'b1) b_wcnt <= b_wcnt + 1;
      if (a_rv === 1'b1) a_rvcnt <= a_rvcnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic a_go(input logic pe, input logic [63:0] n, input logic [63:0] v);
      a_patch = pe; a_noun = n; a_verb = v; a_start = 1'b1;
      @(posedge clk); #1 a_start = 1'b0;
      @(negedge clk);
      chk("a_corerst_on", a_core_rst, 1); chk("a_busy_corerst", a_busy, 1);
      chk("a_err_cleared", a_err, 0);     chk("a_run_off_corerst", a_core_run, 0);
      @(negedge clk);
      chk("a_corerst_off", a_core_rst, 0); chk("a_ready_load", a_if.in_ready, 1);
      @(posedge clk); #1;
   endtask

   task automatic a_send(input logic [63:0] w, input logic last);
      int g = 0;
      a_if.in_valid = 1'b1; a_if.in_word = w; a_if.in_last = last;
      @(negedge clk);
      while (a_if.in_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
      chk("a_ready_wait", a_if.in_ready, 1);
      @(posedge clk); #1;
      a_if.in_valid = 1'b0; a_if.in_last = 1'b0;
   endtask

   logic [63:0] prog [$];

   task automatic a_stream();
      for (int i = 0; i < prog.size(); i++) a_send(prog[i], (i == prog.size() - 1));
   endtask

   task automatic a_finish(input string tag, input logic [63:0] exp_res, input int exp_wr, input int base);
      int g = 0;
      @(negedge clk);
      while (a_rv !== 1'b1 && g < 200) begin @(negedge clk); g++; end
      chk({tag, "_valid"}, a_rv, 1);
      chk({tag, "_result"}, a_result, exp_res);
      chk({tag, "_err"}, a_err, 0);
      chk({tag, "_busy"}, a_busy, 0);
      chk({tag, "_run_done"}, a_core_run, 1);
      chk({tag, "_writes"}, 64'(a_wcnt - base), 64'(exp_wr));
      @(negedge clk);
      chk({tag, "_pulse"}, a_rv, 0);
      chk({tag, "_hold"}, a_result, exp_res);
      @(posedge clk); #1;
   endtask

   task automatic b_go();
      b_start = 1'b1;
      @(posedge clk); #1 b_start = 1'b0;
      @(negedge clk);
      chk("b_err_cleared", b_err, 0); chk("b_corerst_on", b_core_rst, 1);
      @(posedge clk); #1;
   endtask

   task automatic b_send(input logic [63:0] w, input logic last, output logic acc);
      int g = 0;
      b_if.in_valid = 1'b1; b_if.in_word = w; b_if.in_last = last;
      @(negedge clk);
      while (b_if.in_ready !== 1'b1 && g < 5) begin @(negedge clk); g++; end
      acc = (b_if.in_ready === 1'b1);
      if (acc) begin @(posedge clk); #1; end
      b_if.in_valid = 1'b0; b_if.in_last = 1'b0;
   endtask

   initial begin
      int base, rvb, nacc, runs, g;
      logic acc;
      reset = 1'b1;
      a_start = 0; a_patch = 0; a_noun = 0; a_verb = 0;
      b_start = 0; b_patch = 0; b_noun = 0; b_verb = 0;
      a_if.in_valid = 0; a_if.in_last = 0; a_if.in_word = 0;
      b_if.in_valid = 0; b_if.in_last = 0; b_if.in_word = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_core_reset", a_core_rst, 1); chk("rst_ready", a_if.in_ready, 0);
      chk("rst_wr", a_core_wr, 0);          chk("rst_run", a_core_run, 0);
      chk("rst_result", a_result, 0);       chk("rst_rv", a_rv, 0);
      chk("rst_err", a_err, 0);             chk("rst_busy", a_busy, 0);
      chk("rst_b_busy", b_busy, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("idle_core_reset", a_core_rst, 0);
      @(posedge clk); #1;

      // 1,0,0,0,99 -> mem[0] = 1+1
      base = a_wcnt; prog = '{64'd1, 64'd0, 64'd0, 64'd0, 64'd99};
      a_go(1'b0, 64'd0, 64'd0); a_stream(); a_finish("p1", 64'd2, 5, base);

      // mem[3]=30+40=70, mem[0]=70*50
      base = a_wcnt;
      prog = '{64'd1, 64'd9, 64'd10, 64'd3, 64'd2, 64'd3, 64'd11, 64'd0, 64'd99, 64'd30, 64'd40, 64'd50};
      a_go(1'b0, 64'd0, 64'd0); a_stream(); a_finish("p2", 64'd3500, 12, base);

      base = a_wcnt;
      a_go(1'b1, 64'd9, 64'd10); a_stream(); a_finish("p3", 64'd3500, 12, base);
      chk("p3_word1", wlog[(base + 1) % 64], 64'd9);
      chk("p3_word2", wlog[(base + 2) % 64], 64'd10);

      // Words 1,2 zeroed in the stream: only the patch restores 9,10.
      base = a_wcnt; prog[1] = 64'd0; prog[2] = 64'd0;
      a_go(1'b1, 64'd9, 64'd10); a_stream(); a_finish("p4", 64'd3500, 12, base);
      chk("p4_word1", wlog[(base + 1) % 64], 64'd9);
      chk("p4_word2", wlog[(base + 2) % 64], 64'd10);
      chk("p4_word3", wlog[(base + 3) % 64], 64'd3);

      // Unpatched: mem[3]=1+1=2, mem[0]=2*50
      base = a_wcnt;
      a_go(1'b0, 64'd9, 64'd10); a_stream(); a_finish("p5", 64'd100, 12, base);
      chk("p5_word1", wlog[(base + 1) % 64], 64'd0);

      // Reset in the middle of the third word, then a clean reload.
      a_go(1'b0, 64'd0, 64'd0);
      a_send(64'd1, 1'b0); a_send(64'd9, 1'b0);
      a_if.in_valid = 1'b1; a_if.in_word = 64'd10; reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_core_reset", a_core_rst, 1);
      @(posedge clk); #1 reset = 1'b0; a_if.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_busy", a_busy, 0);     chk("mid_rst_ready", a_if.in_ready, 0);
      chk("mid_rst_result", a_result, 0); chk("mid_rst_rv", a_rv, 0);
      chk("mid_rst_wr", a_core_wr, 0);
      @(posedge clk); #1;
      rvb = a_rvcnt; base = a_wcnt;
      prog = '{64'd1, 64'd9, 64'd10, 64'd3, 64'd2, 64'd3, 64'd11, 64'd0, 64'd99, 64'd30, 64'd40, 64'd50};
      a_go(1'b0, 64'd0, 64'd0); a_stream(); a_finish("p6", 64'd3500, 12, base);
      chk("p6_rv_pulses", 64'(a_rvcnt - rvb), 64'd1);

      // Overflow: MaxWords=8, ten words without last.
      base = b_wcnt; nacc = 0;
      b_go();
      for (int i = 0; i < 10; i++) begin
         b_send(64'(100 + i), 1'b0, acc);
         if (acc) nacc++;
      end
      chk("ovf_accepted", 64'(nacc), 64'd8);
      chk("ovf_writes", 64'(b_wcnt - base), 64'd8);
      chk("ovf_err", b_err, 2'd1);
      chk("ovf_ready", b_if.in_ready, 0);
      chk("ovf_busy", b_busy, 0);
      chk("ovf_run", b_core_run, 0);

      // Timeout: TimeoutCycles=16, stub never halts; a start in RUN is ignored.
      b_go();
      b_send(64'd99, 1'b1, acc);
      chk("to_accept", 64'(acc), 64'd1);
      runs = 0; g = 0;
      while (b_err === 2'd0 && g < 100) begin
         @(negedge clk);
         if (b_core_run === 1'b1) runs++;
         b_start = (runs == 3) && (b_core_run === 1'b1);
         g++;
      end
      b_start = 1'b0;
      chk("to_run_cycles", 64'(runs), 64'd16);
      chk("to_err", b_err, 2'd2);
      chk("to_run_off", b_core_run, 0);
      chk("to_busy", b_busy, 0);
      chk("to_result", b_result, 0);
      chk("to_rv", b_rv, 0);

      @(posedge clk); #1;
      chk("bus_monitor", 64'(mon_bad), 64'd0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/intcode_host.md
INTCODE_HOST -- requirements
Module: intcode_host

Interface
REQ-001 Parameter MaxWords, default 256: maximum program length in words; 256 matches the core's 8-bit memory address space.
REQ-002 Parameter TimeoutCycles, default 65535: maximum number of RUN cycles before the run is aborted.
REQ-003 clk  input  1  clock; all logic on its rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle request to load and run a program.
REQ-006 patch_en  input  1  sampled at start; enables noun/verb substitution.
REQ-007 noun, verb  input  64 each  sampled at start; replace program words 1 and 2.
REQ-008 in_valid / in_ready / in_last  input / output / input  1 each  program word stream handshake.
REQ-009 in_word  input  64  program word.
REQ-010 core_reset / core_write_program / core_run_program  output  1 each  core control.
REQ-011 core_data  inout  64  shared core data bus; the host drives it only in LOAD.
REQ-012 core_halt  input  1  core halted, result valid on core_data.
REQ-013 result  output  64  captured core result.
REQ-014 result_valid  output  1  one-cycle pulse when result updates.
REQ-015 busy  output  1  high in every state except IDLE, DONE and ERROR.
REQ-016 error_code  output  2  0 = none, 1 = overflow, 2 = timeout.

Function
REQ-017 The FSM SHALL use the states IDLE, CORE_RST, LOAD, RUN, DONE and ERROR.
REQ-018 start SHALL be accepted in IDLE, DONE or ERROR, moving to CORE_RST, clearing error_code and latching patch_en, noun and verb; start in any other state SHALL be ignored.
REQ-019 CORE_RST SHALL assert core_reset for exactly one cycle, clear the word index to 0, then enter LOAD.
REQ-020 In LOAD, in_ready SHALL be 1; a word SHALL be accepted when in_valid and in_ready are both high.
REQ-021 A word accepted in cycle N SHALL appear on core_data with core_write_program=1 in cycle N+1 only; the core stores it at the current word index.
REQ-022 With patch_en latched, the words at index 1 and 2 SHALL be replaced by noun and verb respectively; all other words SHALL pass unchanged.
REQ-023 An accepted word with in_last=1 SHALL complete its write cycle, then the FSM SHALL enter RUN.
REQ-024 Overflow: a word accepted at index MaxWords-1 without in_last SHALL be written, then the FSM SHALL enter ERROR with error_code=1, and in_ready SHALL drop.
REQ-025 In RUN, core_run_program SHALL be 1, core_data SHALL be high-Z, and a 32-bit cycle counter SHALL start from 0.
REQ-026 core_halt=1 in RUN SHALL capture core_data into result in that cycle; result_valid SHALL pulse in the next cycle, together with entry into DONE.
REQ-027 Timeout: when the counter reaches TimeoutCycles-1 without core_halt, the FSM SHALL enter ERROR with error_code=2.
REQ-028 A simultaneous halt and timeout SHALL be treated as halt.
REQ-029 core_run_program SHALL remain 1 in DONE so that the core keeps driving core_data; it SHALL be 0 in ERROR and IDLE.
REQ-030 core_data SHALL be high-Z in every state except the write cycles of LOAD.

Reset
REQ-031 Reset SHALL force: state IDLE, in_ready 0, core_write_program 0, core_run_program 0, core_reset 1 for the reset cycle, result 0, result_valid 0, error_code 0, busy 0, core_data high-Z.
REQ-032 Reset asserted during LOAD or RUN SHALL abandon the operation; no result_valid pulse SHALL follow.

Structure
REQ-033 Package intcode_host_pkg SHALL hold the state enum, the error_code enum, WordSize=64 and the patch indices 1 and 2.
REQ-034 One sub-module SHALL be used: intcode_host_timer, a loadable cycle counter with a terminal-count flag, used for the timeout.
REQ-035 The bench SHALL connect the host to the intcode core, with a pulldown-free bus check that flags X or multiple drivers on core_data.

Verification
REQ-036 Stream 1,0,0,0,99 with patch_en=0 -> five write cycles, then result=2, result_valid one cycle, error_code=0.
REQ-037 Stream 1,9,10,3,2,3,11,0,99,30,40,50 -> result=3500.
REQ-038 Same stream with patch_en=1, noun=9, verb=10 -> words 1 and 2 are written as 9 and 10, result=3500.
REQ-039 TimeoutCycles=16, core stub holding core_halt=0 -> ERROR, error_code=2 after 16 RUN cycles, core_run_program=0.
REQ-040 MaxWords=8, ten words with no in_last -> eight writes, then error_code=1 and in_ready=0.
REQ-041 Reset asserted during the third LOAD word, then a fresh start -> clean reload and the correct result, with no stale result_valid.
